// File: rtl/ysyx_22050550_axi_arbiter.sv
// rtl/ysyx_22050550_axi_arbiter.sv - two-requester round-robin arbiter onto one AXI master port
// One outstanding transaction; requester 0 is read-only, requester 1 reads and writes.
module ysyx_22050550_axi_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic            clock,
   input  logic            reset,
   // requester 0 read
   input  logic            s0_ar_valid,
   input  logic [AW-1:0]   s0_ar_addr,
   input  logic [7:0]      s0_ar_len,
   input  logic [2:0]      s0_ar_size,
   input  logic [1:0]      s0_ar_burst,
   output logic            s0_ar_ready,
   output logic            s0_r_valid,
   output logic [DW-1:0]   s0_r_data,
   output logic            s0_r_last,
   input  logic            s0_r_ready,
   // requester 1 read
   input  logic            s1_ar_valid,
   input  logic [AW-1:0]   s1_ar_addr,
   input  logic [7:0]      s1_ar_len,
   input  logic [2:0]      s1_ar_size,
   input  logic [1:0]      s1_ar_burst,
   output logic            s1_ar_ready,
   output logic            s1_r_valid,
   output logic [DW-1:0]   s1_r_data,
   output logic            s1_r_last,
   input  logic            s1_r_ready,
   // requester 1 write
   input  logic            s1_aw_valid,
   input  logic [AW-1:0]   s1_aw_addr,
   input  logic [7:0]      s1_aw_len,
   input  logic [2:0]      s1_aw_size,
   input  logic [1:0]      s1_aw_burst,
   output logic            s1_aw_ready,
   input  logic            s1_w_valid,
   input  logic [DW-1:0]   s1_w_data,
   input  logic [DW/8-1:0] s1_w_strb,
   input  logic            s1_w_last,
   output logic            s1_w_ready,
   output logic            s1_b_valid,
   input  logic            s1_b_ready,
   // master port
   output logic            m_ar_valid,
   output logic [AW-1:0]   m_ar_addr,
   output logic [7:0]      m_ar_len,
   output logic [2:0]      m_ar_size,
   output logic [1:0]      m_ar_burst,
   input  logic            m_ar_ready,
   input  logic            m_r_valid,
   input  logic [DW-1:0]   m_r_data,
   input  logic            m_r_last,
   output logic            m_r_ready,
   output logic            m_aw_valid,
   output logic [AW-1:0]   m_aw_addr,
   output logic [7:0]      m_aw_len,
   output logic [2:0]      m_aw_size,
   output logic [1:0]      m_aw_burst,
   input  logic            m_aw_ready,
   output logic            m_w_valid,
   output logic [DW-1:0]   m_w_data,
   output logic [DW/8-1:0] m_w_strb,
   output logic            m_w_last,
   input  logic            m_w_ready,
   input  logic            m_b_valid,
   output logic            m_b_ready,
   output logic            busy,
   output logic            burst_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WADDR = 3'd3,
      WDATA = 3'd4,
      WRESP = 3'd5
   } state_t;

   state_t      state, state_n;
   logic        owner, owner_n;
   logic        last_grant, last_grant_n;
   logic [8:0]  beat, beat_n;
   logic [7:0]  len_q, len_n;
   logic        burst_err_n;
   logic        grant;

   logic            req0, req1;
   logic            own_ar_valid;
   logic [AW-1:0]   own_ar_addr;
   logic [7:0]      own_ar_len;
   logic [2:0]      own_ar_size;
   logic [1:0]      own_ar_burst;
   logic            own_r_ready;

   assign req0 = s0_ar_valid;
   assign req1 = s1_aw_valid | s1_ar_valid;

   assign own_ar_valid = owner ? s1_ar_valid : s0_ar_valid;
   assign own_ar_addr  = owner ? s1_ar_addr  : s0_ar_addr;
   assign own_ar_len   = owner ? s1_ar_len   : s0_ar_len;
   assign own_ar_size  = owner ? s1_ar_size  : s0_ar_size;
   assign own_ar_burst = owner ? s1_ar_burst : s0_ar_burst;
   assign own_r_ready  = owner ? s1_r_ready  : s0_r_ready;

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         beat       <= 9'd0;
         len_q      <= 8'd0;
         burst_err  <= 1'b0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         last_grant <= last_grant_n;
         beat       <= beat_n;
         len_q      <= len_n;
         burst_err  <= burst_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_grant_n = last_grant;
      beat_n       = beat;
      len_n        = len_q;
      burst_err_n  = 1'b0;
      grant        = 1'b0;

      s0_ar_ready = 1'b0;
      s0_r_valid  = 1'b0;
      s0_r_data   = '0;
      s0_r_last   = 1'b0;
      s1_ar_ready = 1'b0;
      s1_r_valid  = 1'b0;
      s1_r_data   = '0;
      s1_r_last   = 1'b0;
      s1_aw_ready = 1'b0;
      s1_w_ready  = 1'b0;
      s1_b_valid  = 1'b0;
      m_ar_valid  = 1'b0;
      m_ar_addr   = '0;
      m_ar_len    = '0;
      m_ar_size   = '0;
      m_ar_burst  = '0;
      m_r_ready   = 1'b0;
      m_aw_valid  = 1'b0;
      m_aw_addr   = '0;
      m_aw_len    = '0;
      m_aw_size   = '0;
      m_aw_burst  = '0;
      m_w_valid   = 1'b0;
      m_w_data    = '0;
      m_w_strb    = '0;
      m_w_last    = 1'b0;
      m_b_ready   = 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant   = (req0 && req1) ? ~last_grant : req1;
               owner_n = grant;
               // requester 1 prefers its write when both of its channels are valid
               state_n = (grant && s1_aw_valid) ? WADDR : RADDR;
            end
         end
         RADDR: begin
            m_ar_valid = own_ar_valid;
            m_ar_addr  = own_ar_addr;
            m_ar_len   = own_ar_len;
            m_ar_size  = own_ar_size;
            m_ar_burst = own_ar_burst;
            if (owner) s1_ar_ready = m_ar_ready;
            else       s0_ar_ready = m_ar_ready;
            if (own_ar_valid && m_ar_ready) begin
               len_n   = own_ar_len;
               beat_n  = 9'd0;
               state_n = RDATA;
            end else if (!own_ar_valid) begin
               state_n = IDLE;
            end
         end
         RDATA: begin
            if (owner) begin
               s1_r_valid = m_r_valid;
               s1_r_data  = m_r_data;
               s1_r_last  = m_r_last;
            end else begin
               s0_r_valid = m_r_valid;
               s0_r_data  = m_r_data;
               s0_r_last  = m_r_last;
            end
            m_r_ready = own_r_ready;
            if (m_r_valid && own_r_ready) begin
               beat_n = beat + 9'd1;
               if (m_r_last) begin
                  state_n      = IDLE;
                  last_grant_n = owner;
                  burst_err_n  = ((beat + 9'd1) != ({1'b0, len_q} + 9'd1));
               end
            end
         end
         WADDR: begin
            m_aw_valid  = s1_aw_valid;
            m_aw_addr   = s1_aw_addr;
            m_aw_len    = s1_aw_len;
            m_aw_size   = s1_aw_size;
            m_aw_burst  = s1_aw_burst;
            s1_aw_ready = m_aw_ready;
            if (s1_aw_valid && m_aw_ready) state_n = WDATA;
         end
         WDATA: begin
            m_w_valid  = s1_w_valid;
            m_w_data   = s1_w_data;
            m_w_strb   = s1_w_strb;
            m_w_last   = s1_w_last;
            s1_w_ready = m_w_ready;
            if (s1_w_valid && m_w_ready && s1_w_last) state_n = WRESP;
         end
         WRESP: begin
            s1_b_valid = m_b_valid;
            m_b_ready  = s1_b_ready;
            if (m_b_valid && s1_b_ready) begin
               state_n      = IDLE;
               last_grant_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_22050550_axi_arbiter.sv
// tb/tb_ysyx_22050550_axi_arbiter.sv - directed bench for the two-requester AXI arbiter
module tb_ysyx_22050550_axi_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
   localparam logic [63:0] A1 = 64'h0000_0000_8000_1000;

   logic clock, reset;
   logic s0_ar_valid; logic [AW-1:0] s0_ar_addr; logic [7:0] s0_ar_len; logic [2:0] s0_ar_size; logic [1:0] s0_ar_burst;
   logic s0_ar_ready, s0_r_valid, s0_r_last, s0_r_ready; logic [DW-1:0] s0_r_data;
   logic s1_ar_valid; logic [AW-1:0] s1_ar_addr; logic [7:0] s1_ar_len; logic [2:0] s1_ar_size; logic [1:0] s1_ar_burst;
   logic s1_ar_ready, s1_r_valid, s1_r_last, s1_r_ready; logic [DW-1:0] s1_r_data;
   logic s1_aw_valid; logic [AW-1:0] s1_aw_addr; logic [7:0] s1_aw_len; logic [2:0] s1_aw_size; logic [1:0] s1_aw_burst;
   logic s1_aw_ready, s1_w_valid, s1_w_last, s1_w_ready, s1_b_valid, s1_b_ready;
   logic [DW-1:0] s1_w_data; logic [DW/8-1:0] s1_w_strb;
   logic m_ar_valid; logic [AW-1:0] m_ar_addr; logic [7:0] m_ar_len; logic [2:0] m_ar_size; logic [1:0] m_ar_burst;
   logic m_ar_ready, m_r_valid, m_r_last, m_r_ready; logic [DW-1:0] m_r_data;
   logic m_aw_valid; logic [AW-1:0] m_aw_addr; logic [7:0] m_aw_len; logic [2:0] m_aw_size; logic [1:0] m_aw_burst;
   logic m_aw_ready, m_w_valid, m_w_last, m_w_ready, m_b_valid, m_b_ready;
   logic [DW-1:0] m_w_data; logic [DW/8-1:0] m_w_strb;
   logic busy, burst_err;
   logic any_out;

   int n_cmp = 0;
   int n_bad = 0;

   ysyx_22050550_axi_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock(clock), .reset(reset),
      .s0_ar_valid(s0_ar_valid), .s0_ar_addr(s0_ar_addr), .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size),
      .s0_ar_burst(s0_ar_burst), .s0_ar_ready(s0_ar_ready),
      .s0_r_valid(s0_r_valid), .s0_r_data(s0_r_data), .s0_r_last(s0_r_last), .s0_r_ready(s0_r_ready),
      .s1_ar_valid(s1_ar_valid), .s1_ar_addr(s1_ar_addr), .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size),
      .s1_ar_burst(s1_ar_burst), .s1_ar_ready(s1_ar_ready),
      .s1_r_valid(s1_r_valid), .s1_r_data(s1_r_data), .s1_r_last(s1_r_last), .s1_r_ready(s1_r_ready),
      .s1_aw_valid(s1_aw_valid), .s1_aw_addr(s1_aw_addr), .s1_aw_len(s1_aw_len), .s1_aw_size(s1_aw_size),
      .s1_aw_burst(s1_aw_burst), .s1_aw_ready(s1_aw_ready),
      .s1_w_valid(s1_w_valid), .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb), .s1_w_last(s1_w_last),
      .s1_w_ready(s1_w_ready), .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready),
      .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
      .m_ar_burst(m_ar_burst), .m_ar_ready(m_ar_ready),
      .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_ready(m_r_ready),
      .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
      .m_aw_burst(m_aw_burst), .m_aw_ready(m_aw_ready),
      .m_w_valid(m_w_valid), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
      .m_w_ready(m_w_ready), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .busy(busy), .burst_err(burst_err)
   );

   assign any_out = |{s0_ar_ready, s0_r_valid, s0_r_data, s0_r_last,
                      s1_ar_ready, s1_r_valid, s1_r_data, s1_r_last,
                      s1_aw_ready, s1_w_ready, s1_b_valid,
                      m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
                      m_aw_valid, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst,
                      m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready, busy, burst_err};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Serves one read from IDLE: arbitration cycle, optional AR stall, then beats 0..last_at.
   task automatic serve_read(input int who, input logic [7:0] len, input int last_at, input int ar_wait,
                             input logic [63:0] dbase, input logic exp_err);
      if (who == 1) s1_ar_len = len; else s0_ar_len = len;
      #1;
      check("idle_no_ar", 64'(m_ar_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      tick();
      m_ar_ready = 1'b0;
      #1;
      check("raddr_valid", 64'(m_ar_valid), 64'd1);
      check("raddr_owner", m_ar_addr, (who == 1) ? A1 : A0);
      check("raddr_len", 64'(m_ar_len), 64'(len));
      for (int i = 0; i < ar_wait; i++) begin
         check("raddr_stall_rdy", 64'(who == 1 ? s1_ar_ready : s0_ar_ready), 64'd0);
         tick();
      end
      m_ar_ready = 1'b1;
      #1;
      check("raddr_rdy", 64'(who == 1 ? s1_ar_ready : s0_ar_ready), 64'd1);
      check("raddr_other_rdy", 64'(who == 1 ? s0_ar_ready : s1_ar_ready), 64'd0);
      tick();
      if (who == 1) s1_ar_valid = 1'b0; else s0_ar_valid = 1'b0;
      m_ar_ready = 1'b0;
      for (int b = 0; b <= last_at; b++) begin
         m_r_valid = 1'b1;
         m_r_data  = dbase + 64'(b);
         m_r_last  = (b == last_at);
         if (who == 1) s1_r_ready = 1'b1; else s0_r_ready = 1'b1;
         #1;
         check("rdata_valid", 64'(who == 1 ? s1_r_valid : s0_r_valid), 64'd1);
         check("rdata_data", (who == 1) ? s1_r_data : s0_r_data, dbase + 64'(b));
         check("rdata_last", 64'(who == 1 ? s1_r_last : s0_r_last), 64'(b == last_at));
         check("rdata_other", 64'(who == 1 ? s0_r_valid : s1_r_valid), 64'd0);
         check("rdata_mready", 64'(m_r_ready), 64'd1);
         check("rdata_no_err", 64'(burst_err), 64'd0);
         tick();
      end
      m_r_valid = 1'b0;
      m_r_last  = 1'b0;
      s0_r_ready = 1'b0;
      s1_r_ready = 1'b0;
      #1;
      check("rdone_busy", 64'(busy), 64'd0);
      check("rdone_err", 64'(burst_err), 64'(exp_err));
   endtask

   initial begin
      reset = 1'b0;
      s0_ar_valid = 0; s0_ar_addr = A0; s0_ar_len = 0; s0_ar_size = 3'd3; s0_ar_burst = 2'd1; s0_r_ready = 0;
      s1_ar_valid = 0; s1_ar_addr = A1; s1_ar_len = 0; s1_ar_size = 3'd3; s1_ar_burst = 2'd1; s1_r_ready = 0;
      s1_aw_valid = 0; s1_aw_addr = 0; s1_aw_len = 0; s1_aw_size = 0; s1_aw_burst = 0;
      s1_w_valid = 0; s1_w_data = 0; s1_w_strb = 0; s1_w_last = 0; s1_b_ready = 0;
      m_ar_ready = 0; m_r_valid = 1'b1; m_r_data = 64'hdead_beef_dead_beef; m_r_last = 1'b1;
      m_aw_ready = 0; m_w_ready = 0; m_b_valid = 0;

      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", 64'(any_out), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      m_r_valid = 1'b0; m_r_last = 1'b0;
      repeat (3) tick();
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_outputs", 64'(any_out), 64'd0);

      // s0 single beat read, AR accepted two cycles into RADDR
      s0_ar_valid = 1'b1;
      serve_read(0, 8'd0, 0, 1, 64'h1122_3344_5566_7788, 1'b0);

      // s1 write with a delayed response
      s1_aw_valid = 1'b1; s1_aw_addr = 64'h0000_0000_a000_03f8; s1_aw_len = 0; s1_aw_size = 3'd0; s1_aw_burst = 2'd1;
      s1_w_valid = 1'b1; s1_w_data = 64'h41; s1_w_strb = 8'h01; s1_w_last = 1'b1;
      s1_ar_valid = 1'b1;
      #1;
      check("widle_no_aw", 64'(m_aw_valid), 64'd0);
      tick();
      m_aw_ready = 1'b1;
      #1;
      check("waddr_valid", 64'(m_aw_valid), 64'd1);
      check("waddr_addr", m_aw_addr, 64'h0000_0000_a000_03f8);
      check("waddr_rdy", 64'(s1_aw_ready), 64'd1);
      check("waddr_no_ar", 64'(m_ar_valid), 64'd0);
      check("waddr_no_w", 64'(m_w_valid), 64'd0);
      tick();
      s1_aw_valid = 1'b0; s1_ar_valid = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b1;
      #1;
      check("wdata_valid", 64'(m_w_valid), 64'd1);
      check("wdata_data", m_w_data, 64'h41);
      check("wdata_strb", 64'(m_w_strb), 64'h01);
      check("wdata_last", 64'(m_w_last), 64'd1);
      check("wdata_rdy", 64'(s1_w_ready), 64'd1);
      tick();
      s1_w_valid = 1'b0; m_w_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s1_b_ready = (i != 2);
         #1;
         check("wresp_busy", 64'(busy), 64'd1);
         check("wresp_bready", 64'(m_b_ready), 64'(i != 2));
         check("wresp_no_b", 64'(s1_b_valid), 64'd0);
         tick();
      end
      m_b_valid = 1'b1; s1_b_ready = 1'b1;
      #1;
      check("wresp_bvalid", 64'(s1_b_valid), 64'd1);
      tick();
      m_b_valid = 1'b0; s1_b_ready = 1'b0;
      #1;
      check("wdone_busy", 64'(busy), 64'd0);
      check("wdone_bvalid", 64'(s1_b_valid), 64'd0);

      // simultaneous reads twice: expect s0, s1, s0, s1
      s0_ar_valid = 1'b1; s1_ar_valid = 1'b1;
      serve_read(0, 8'd0, 0, 0, 64'h0a00, 1'b0);
      s0_ar_valid = 1'b1;
      serve_read(1, 8'd1, 1, 0, 64'h1b00, 1'b0);
      s1_ar_valid = 1'b1;
      serve_read(0, 8'd0, 0, 0, 64'h0c00, 1'b0);
      serve_read(1, 8'd0, 0, 0, 64'h1d00, 1'b0);

      // short burst: len=3 but last arrives on beat 2
      s0_ar_valid = 1'b1;
      serve_read(0, 8'd3, 2, 0, 64'h2000, 1'b1);
      tick();
      check("err_pulse_end", 64'(burst_err), 64'd0);
      check("err_idle", 64'(busy), 64'd0);

      // reset during beat 1 of a 4-beat read
      s0_ar_valid = 1'b1; s0_ar_len = 8'd3;
      tick();
      m_ar_ready = 1'b1;
      tick();
      s0_ar_valid = 1'b0; m_ar_ready = 1'b0;
      m_r_valid = 1'b1; m_r_data = 64'h3000; m_r_last = 1'b0; s0_r_ready = 1'b1;
      tick();
      m_r_data = 64'h3001;
      #1;
      check("mid_rvalid", 64'(s0_r_valid), 64'd1);
      reset = 1'b0;
      #1;
      check("mid_reset_busy", 64'(busy), 64'd0);
      check("mid_reset_outputs", 64'(any_out), 64'd0);
      tick();
      reset = 1'b1;
      m_r_valid = 1'b0; s0_r_ready = 1'b0;
      tick();
      check("after_reset_idle", 64'(busy), 64'd0);
      s1_ar_valid = 1'b1;
      serve_read(1, 8'd1, 1, 0, 64'h4000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22050550_axi_arbiter.md
Name: ysyx_22050550_axi_arbiter

Overview:
- Shares the single external AXI master port between requester 0 (IFU/ICache refill, read-only) and requester 1 (LSU: DCache refill/writeback plus uncached device access, read and write).
- Allows one outstanding transaction in total.
- Grants round-robin between the two requesters, sequences AR/R or AW/W/B for the owner, and flags burst-length violations.
- Sits between the IFU/LSU/cache bus ports and the SoC AXI interface.

Parameters:
- AW, 64, address width
- DW, 64, data width (strobe width DW/8)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- s0_ar_{valid,addr,len,size,burst}  in  1/AW/8/3/2  requester 0 read address
- s0_ar_ready  out  1  read-address accept to requester 0
- s0_r_{valid,data,last}  out  1/DW/1  read data to requester 0
- s0_r_ready  in  1  requester 0 read-data accept
- s1_ar_{valid,addr,len,size,burst}  in  1/AW/8/3/2  requester 1 read address
- s1_ar_ready  out  1
- s1_r_{valid,data,last}  out  1/DW/1
- s1_r_ready  in  1
- s1_aw_{valid,addr,len,size,burst}  in  1/AW/8/3/2  requester 1 write address
- s1_aw_ready  out  1
- s1_w_{valid,data,strb,last}  in  1/DW/DW/8/1  requester 1 write data
- s1_w_ready  out  1
- s1_b_valid  out  1  write response to requester 1
- s1_b_ready  in  1
- m_ar_{valid,addr,len,size,burst}  out  1/AW/8/3/2  master read address
- m_ar_ready  in  1
- m_r_{valid,data,last}  in  1/DW/1  master read data
- m_r_ready  out  1
- m_aw_{valid,addr,len,size,burst}  out  1/AW/8/3/2  master write address
- m_aw_ready  in  1
- m_w_{valid,data,strb,last}  out  1/DW/DW/8/1  master write data
- m_w_ready  in  1
- m_b_valid  in  1  master write response
- m_b_ready  out  1
- busy  out  1  high whenever state != IDLE
- burst_err  out  1  one-cycle pulse on a read-beat-count mismatch

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- Registers: state, owner (0/1), last_grant, beat[8:0].
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=0, last_grant=1 (so requester 0 wins the first tie), beat=0, burst_err=0.
  - All valid/ready outputs 0; all address/data outputs 0.
  - A reset mid-transaction abandons it; no completion is signalled.
- IDLE:
  - req0 = s0_ar_valid; req1 = s1_aw_valid | s1_ar_valid.
  - Only one requesting: grant it.
  - Both requesting: grant !last_grant.
  - Requester 1 with both aw and ar valid: write wins.
  - Grant is registered. The next state is RADDR or WADDR, so arbitration latency is 1 cycle and IDLE never forwards a valid.
- Forwarding:
  - Only the owner's channels are connected combinationally to m_*.
  - The non-owner's ready/valid/data outputs are 0.
  - All m_* valid/ready outputs are 0 in states that do not use that channel.
- RADDR:
  - m_ar_* = owner ar_*; owner ar_ready = m_ar_ready.
  - On handshake: latch len, beat=0, go to RDATA.
  - If the owner drops ar_valid before the handshake (protocol violation): return to IDLE, last_grant unchanged.
- RDATA:
  - Owner r_* = m_r_*; m_r_ready = owner r_ready.
  - Each handshake increments beat.
  - On a handshake with m_r_last=1: go to IDLE, last_grant=owner.
  - If beat+1 != len+1 at that point, pulse burst_err the next cycle.
  - m_r_last is forwarded unmodified.
- WADDR: m_aw_* = s1_aw_*. On handshake go to WDATA.
- WDATA: m_w_* = s1_w_*. On a handshake with s1_w_last=1 go to WRESP.
- WRESP:
  - s1_b_valid = m_b_valid; m_b_ready = s1_b_ready.
  - On handshake go to IDLE, last_grant=1.
- Requests arriving during a transaction wait and are evaluated in IDLE only. Back-to-back grants therefore carry one idle cycle between transactions.
- Requesters keep ar/aw/w valid and payload stable until ready, per AXI.

Test Plan:
- Reset low for 3 cycles, with m_r_valid=1 during reset → all outputs 0, busy=0; after release with no requests, state stays IDLE.
- s0 single read (addr 0x80000000, len 0), m_ar_ready=1 at T+2, one r beat data 0x1122334455667788 last=1 → s0 receives the data with r_last=1, busy drops the cycle after; s1_r_valid stays 0 throughout.
- s0 and s1 both assert ar in the same cycle, twice in sequence → order is s0, s1, s0, s1; each grant starts 1 cycle after IDLE.
- s1 write: aw addr 0xa00003f8 len 0, w data 0x41 strb 0x01 last=1, b delayed 4 cycles → m_b_ready mirrors s1_b_ready, busy=1 until the b handshake, then IDLE.
- s0 read with len=3 where the slave asserts m_r_last on beat 2 → burst_err=1 for exactly 1 cycle; arbiter back in IDLE.
- Reset asserted during RDATA beat 1 of 4 → immediate IDLE, all valids 0; after release, a fresh s1 read completes normally.
